// File: rtl/l2_sdp_banked_ram.sv
// Banked simple-dual-port RAM for the L2 data/tag arrays: byte strobes, optional output
// register, zero sweep after reset and a write-first merge for same-address read/write.
module l2_sdp_banked_ram #(
    parameter int DW      = 256,
    parameter int DEPTH   = 1024,
    parameter int BANKS   = 2,
    parameter int OUT_REG = 0,
    parameter int INIT_EN = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DW-1:0]            wdata_i,
    input  logic [DW/8-1:0]          wdata_strob_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DW-1:0]            rdata_o,
    output logic                     rvalid_o,
    output logic                     init_done_o
);
    localparam int AW   = $clog2(DEPTH);
    localparam int BW   = $clog2(BANKS);
    localparam int SW   = DW / 8;
    localparam int ROWS = DEPTH / BANKS;
    localparam int RW   = AW - BW;
    localparam int RWS  = (RW > 0) ? RW : 1;
    localparam int BWS  = (BW > 0) ? BW : 1;

    typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;

    // With a single bank the shift leaves nothing, so the select collapses to bank 0.
    function automatic logic [BWS-1:0] bank_of(input logic [AW-1:0] a);
        logic [AW-1:0] sh;
        sh = a >> RW;
        return sh[BWS-1:0];
    endfunction

    function automatic logic [RWS-1:0] row_of(input logic [AW-1:0] a);
        logic [AW-1:0] m;
        m = a & AW'(ROWS - 1);
        return m[RWS-1:0];
    endfunction

    function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old_d,
                                                 input logic [DW-1:0] new_d,
                                                 input logic [SW-1:0] strb);
        logic [DW-1:0] r;
        r = old_d;
        for (int k = 0; k < SW; k++) begin
            if (strb[k]) r[8*k +: 8] = new_d[8*k +: 8];
            else         r[8*k +: 8] = old_d[8*k +: 8];
        end
        return r;
    endfunction

    state_t           state_r, state_next_s;
    logic [RWS-1:0]   init_row_r;
    logic             ready_s, wr_ok_s, rd_ok_s, byp_s;
    logic [BWS-1:0]   wbank_s, rbank_s, rsel_r;
    logic [RWS-1:0]   wrow_s, rrow_s;
    logic [BANKS*DW-1:0] rd_flat_s;
    logic [DW-1:0]    byp_data_r, s1_data_s;
    logic [SW-1:0]    byp_strb_r;
    logic             rv1_r;

    assign ready_s     = (state_r == READY);
    assign init_done_o = ready_s;
    assign wr_ok_s     = ready_s && we_i;
    assign rd_ok_s     = ready_s && re_i;
    assign byp_s       = rd_ok_s && we_i && (raddr_i == waddr_i);
    assign wbank_s     = bank_of(waddr_i);
    assign rbank_s     = bank_of(raddr_i);
    assign wrow_s      = row_of(waddr_i);
    assign rrow_s      = row_of(raddr_i);

    // Init sweep next-state: INIT walks every row once, READY is absorbing.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            INIT: begin
                if (init_row_r == RWS'(ROWS - 1)) state_next_s = READY;
                else                              state_next_s = INIT;
            end
            READY:   state_next_s = READY;
            default: state_next_s = READY;
        endcase
    end

    // State register and sweep row counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= (INIT_EN != 0) ? INIT : READY;
            init_row_r <= {RWS{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (state_r == INIT) init_row_r <= init_row_r + RWS'(1);
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [DW-1:0] mem_r [ROWS];
        logic [DW-1:0] rd_q_r;
        logic          bank_we_s, bank_re_s;

        assign bank_we_s = wr_ok_s && (wbank_s == BWS'(b));
        assign bank_re_s = rd_ok_s && (rbank_s == BWS'(b));
        assign rd_flat_s[b*DW +: DW] = rd_q_r;

        // Storage: zero fill while sweeping, otherwise strobed byte writes.
        always_ff @(posedge clk_i) begin
            if (state_r == INIT) begin
                mem_r[init_row_r] <= {DW{1'b0}};
            end else if (bank_we_s) begin
                for (int k = 0; k < SW; k++) begin
                    if (wdata_strob_i[k]) mem_r[wrow_s][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end

        // Per-bank read register; it sees the pre-write contents on a same-row collision.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)        rd_q_r <= {DW{1'b0}};
            else if (bank_re_s) rd_q_r <= mem_r[rrow_s];
        end
    end

    // Bank select and bypass bytes travel with the read so the return mux is aligned.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rv1_r      <= 1'b0;
            rsel_r     <= {BWS{1'b0}};
            byp_data_r <= {DW{1'b0}};
            byp_strb_r <= {SW{1'b0}};
        end else begin
            rv1_r <= rd_ok_s;
            if (rd_ok_s) begin
                rsel_r     <= rbank_s;
                byp_data_r <= wdata_i;
                byp_strb_r <= byp_s ? wdata_strob_i : {SW{1'b0}};
            end
        end
    end

    assign s1_data_s = byte_merge(rd_flat_s[rsel_r*DW +: DW], byp_data_r, byp_strb_r);

    if (OUT_REG != 0) begin : g_oreg
        logic [DW-1:0] rdata_r;
        logic          rvalid_r;

        // Optional output stage; data holds between reads.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rdata_r  <= {DW{1'b0}};
                rvalid_r <= 1'b0;
            end else begin
                rvalid_r <= rv1_r;
                if (rv1_r) rdata_r <= s1_data_s;
            end
        end

        assign rdata_o  = rdata_r;
        assign rvalid_o = rvalid_r;
    end else begin : g_noreg
        assign rdata_o  = s1_data_s;
        assign rvalid_o = rv1_r;
    end
endmodule
